// File: rtl/ram_rd_stream_pkg.sv
// Pointer type and increment helper shared by the ram1r1w2c read and write streamers.
// The address field is sized for the widest RAM; each user keeps only its own low bits.
package ram_rd_stream_pkg;

    localparam int PTR_ADDR_MAX = 16;

    typedef struct packed {
        logic                    wrap;
        logic [PTR_ADDR_MAX-1:0] addr;
    } ptr_t;

    // Wraps at depth-1 so non-power-of-two RAMs work; the wrap bit tells full from empty.
    function automatic ptr_t ptr_inc(input ptr_t p, input int unsigned depth);
        ptr_t r;
        r = p;
        if (p.addr == PTR_ADDR_MAX'(depth - 1)) begin
            r.addr = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.addr = p.addr + PTR_ADDR_MAX'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_rd_obuf.sv
// Small synchronous circular FIFO that catches RAM read returns and feeds the output stream.
module ram_rd_obuf #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  doPush, doPop;

    function automatic logic [IDX_W-1:0] idxInc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(DEPTH - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    always_comb begin
        doPush = push_i & ~flush_i;
        doPop  = pop_i & (cnt_q != '0) & ~flush_i;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (doPush) tail_d = idxInc(tail_q);
            if (doPop)  head_d = idxInc(head_q);
            cnt_d = cnt_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible once cnt covers it.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[tail_q] <= data_i;
    end

    assign data_o  = mem_q[head_q];
    assign valid_o = (cnt_q != '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/ram_rd_stream.sv
// Read-side streamer for the ram1r1w2c buffer RAM: issues reads while credit allows,
// tracks the RAM latency with a valid pipe, and streams returned words out through a FIFO.
module ram_rd_stream
    import ram_rd_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int DATA_WIDTH = 8,
    parameter int PIPE       = 0,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [ADDR_WIDTH:0]               wr_ptr,
    output logic [ADDR_WIDTH:0]               rd_ptr,
    output logic [ADDR_WIDTH-1:0]             ram_rdaddr,
    input  logic [DATA_WIDTH-1:0]             ram_rddata,
    output logic [DATA_WIDTH-1:0]             dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic [$clog2(OBUF_DEPTH+1)-1:0]   obuf_cnt
);

    localparam int LAT   = 1 + PIPE;
    localparam int IFL_W = $clog2(LAT + 1);

    logic [ADDR_WIDTH:0] issPtr_q, issPtr_d, rdPtr_q, rdPtr_d;
    logic [LAT-1:0]      vldPipe_q, vldPipe_d;
    logic [IFL_W-1:0]    inflight_q, inflight_d;
    logic                empty, issue, ret;

    function automatic logic [ADDR_WIDTH:0] ptrNext(input logic [ADDR_WIDTH:0] p);
        ptr_t w;
        w.wrap = p[ADDR_WIDTH];
        w.addr = PTR_ADDR_MAX'(p[ADDR_WIDTH-1:0]);
        w      = ptr_inc(w, DEPTH);
        return {w.wrap, w.addr[ADDR_WIDTH-1:0]};
    endfunction

    // rd_ptr moves only on return, so a slot stays owned until its data has landed.
    always_comb begin
        empty      = (issPtr_q == wr_ptr);
        issue      = !empty && ((32'(obuf_cnt) + 32'(inflight_q)) < 32'(OBUF_DEPTH)) && !flush;
        ret        = vldPipe_q[LAT-1];
        issPtr_d   = issPtr_q;
        rdPtr_d    = rdPtr_q;
        inflight_d = inflight_q + IFL_W'(issue) - IFL_W'(ret);
        vldPipe_d  = '0;
        vldPipe_d[0] = issue;
        for (int i = 1; i < LAT; i++) vldPipe_d[i] = vldPipe_q[i-1];
        if (issue) issPtr_d = ptrNext(issPtr_q);
        if (ret)   rdPtr_d  = ptrNext(rdPtr_q);
        if (flush) begin
            issPtr_d   = wr_ptr;
            rdPtr_d    = wr_ptr;
            vldPipe_d  = '0;
            inflight_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issPtr_q   <= '0;
            rdPtr_q    <= '0;
            vldPipe_q  <= '0;
            inflight_q <= '0;
        end else begin
            issPtr_q   <= issPtr_d;
            rdPtr_q    <= rdPtr_d;
            vldPipe_q  <= vldPipe_d;
            inflight_q <= inflight_d;
        end
    end

    ram_rd_obuf #(
        .DEPTH      (OBUF_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (ret),
        .data_i  (ram_rddata),
        .pop_i   (dout_valid & dout_ready),
        .data_o  (dout),
        .valid_o (dout_valid),
        .cnt_o   (obuf_cnt)
    );

    assign ram_rdaddr = issPtr_q[ADDR_WIDTH-1:0];
    assign rd_ptr     = rdPtr_q;

endmodule

// File: tb/tb_ram_rd_stream.sv
// Self-checking bench for ram_rd_stream with three instances: A (DEPTH=4, PIPE=0),
// B (DEPTH=3, PIPE=0) and C (DEPTH=8, PIPE=1), each with a behavioural RAM and a scoreboard.
module tb_ram_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int waitCyc;

    logic       rstnAB, rstnC, flushA, flushB, flushC, readyA, readyB, readyC;
    logic [2:0] wrA, rdA, cntA, wrB, rdB, cntB, cntC;
    logic [1:0] addrA, addrB;
    logic [3:0] wrC, rdC;
    logic [2:0] addrC, addrCq;
    logic [7:0] rdDataA, rdDataB, rdDataC, doutA, doutB, doutC;
    logic       validA, validB, validC;

    logic [7:0] memA [4];
    logic [7:0] memB [4];
    logic [7:0] memC [8];
    logic [7:0] qA[$], qB[$], qC[$];
    logic       monEnC = 1'b1;
    logic [2:0] prevRdB = '0, expRdB = '0;
    logic [2:0] maxCntC = '0;

    ram_rd_stream #(.ADDR_WIDTH(2), .DEPTH(4), .DATA_WIDTH(8), .PIPE(0), .OBUF_DEPTH(4)) dutA (
        .clk(clk), .rst_n(rstnAB), .flush(flushA), .wr_ptr(wrA), .rd_ptr(rdA),
        .ram_rdaddr(addrA), .ram_rddata(rdDataA), .dout(doutA), .dout_valid(validA),
        .dout_ready(readyA), .obuf_cnt(cntA));

    ram_rd_stream #(.ADDR_WIDTH(2), .DEPTH(3), .DATA_WIDTH(8), .PIPE(0), .OBUF_DEPTH(4)) dutB (
        .clk(clk), .rst_n(rstnAB), .flush(flushB), .wr_ptr(wrB), .rd_ptr(rdB),
        .ram_rdaddr(addrB), .ram_rddata(rdDataB), .dout(doutB), .dout_valid(validB),
        .dout_ready(readyB), .obuf_cnt(cntB));

    ram_rd_stream #(.ADDR_WIDTH(3), .DEPTH(8), .DATA_WIDTH(8), .PIPE(1), .OBUF_DEPTH(4)) dutC (
        .clk(clk), .rst_n(rstnC), .flush(flushC), .wr_ptr(wrC), .rd_ptr(rdC),
        .ram_rdaddr(addrC), .ram_rddata(rdDataC), .dout(doutC), .dout_valid(validC),
        .dout_ready(readyC), .obuf_cnt(cntC));

    // Behavioural RAMs: PIPE=0 returns one clock after the address; PIPE=1 reads the array a clock late.
    always @(posedge clk) rdDataA <= memA[addrA];
    always @(posedge clk) rdDataB <= memB[addrB];
    always @(posedge clk) begin
        addrCq  <= addrC;
        rdDataC <= memC[addrCq];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pointer model: {wrap, addr}, wrap toggles when addr steps from depth-1 back to 0.
    function automatic int nextPtr(input int p, input int aw, input int depth);
        int a, w;
        a = p & ((1 << aw) - 1);
        w = (p >> aw) & 1;
        if (a == depth - 1) return (w ^ 1) << aw;
        return (w << aw) | (a + 1);
    endfunction

    function automatic int usedSlots(input int wp, input int rp, input int aw, input int depth);
        int wa, ra;
        wa = wp & ((1 << aw) - 1);
        ra = rp & ((1 << aw) - 1);
        if (((wp >> aw) & 1) == ((rp >> aw) & 1)) return wa - ra;
        return depth - ra + wa;
    endfunction

    // Scoreboard monitors: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (validA && readyA) begin
            checkOutput("A_sb_has_entry", qA.size() != 0, 1);
            if (qA.size() != 0) checkOutput("A_dout", doutA, qA.pop_front());
        end
    end

    always @(negedge clk) begin
        if (validB && readyB) begin
            checkOutput("B_sb_has_entry", qB.size() != 0, 1);
            if (qB.size() != 0) checkOutput("B_dout", doutB, qB.pop_front());
        end
    end

    always @(negedge clk) begin
        if (monEnC && validC && readyC) begin
            checkOutput("C_sb_has_entry", qC.size() != 0, 1);
            if (qC.size() != 0) checkOutput("C_dout", doutC, qC.pop_front());
        end
        if (cntC > maxCntC) maxCntC = cntC;
    end

    // Each rd_ptr step on B must follow the wrap-at-DEPTH sequence.
    always @(negedge clk) begin
        if (rdB !== prevRdB) begin
            expRdB = 3'(nextPtr(int'(expRdB), 2, 3));
            checkOutput("B_rd_step", rdB, expRdB);
            prevRdB = rdB;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expFinal;
        rstnAB = 1'b1; rstnC = 1'b1;
        flushA = 1'b0; flushB = 1'b0; flushC = 1'b0;
        readyA = 1'b1; readyB = 1'b1; readyC = 1'b0;
        wrA = '0; wrB = '0; wrC = '0;
        #1 rstnAB = 1'b0; rstnC = 1'b0;
        @(negedge clk);
        checkOutput("rst_rdA", rdA, 0);
        checkOutput("rst_addrA", addrA, 0);
        checkOutput("rst_validA", validA, 0);
        checkOutput("rst_cntA", cntA, 0);
        checkOutput("rst_rdC", rdC, 0);
        checkOutput("rst_validC", validC, 0);
        @(negedge clk);
        rstnAB = 1'b1; rstnC = 1'b1;

        // A: three words, first one visible two clocks after wr_ptr moves, then back-to-back.
        @(posedge clk); #1;
        memA[0] = 8'h11; memA[1] = 8'h22; memA[2] = 8'h33;
        qA.push_back(8'h11); qA.push_back(8'h22); qA.push_back(8'h33);
        wrA = 3'd3;
        @(negedge clk); checkOutput("A_valid_c0", validA, 0);
        @(negedge clk); checkOutput("A_valid_c1", validA, 0);
        @(negedge clk); checkOutput("A_valid_c2", validA, 1);
        @(negedge clk); checkOutput("A_valid_c3", validA, 1);
        @(negedge clk); checkOutput("A_valid_c4", validA, 1);
        @(negedge clk); checkOutput("A_valid_c5", validA, 0);
        checkOutput("A_rd_final", rdA, 3);
        checkOutput("A_addr_final", addrA, 3);
        checkOutput("A_sb_drained", qA.size(), 0);

        // B: seven words through a three-entry RAM, writer throttled by the returned rd_ptr.
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            waitCyc = 0;
            while (usedSlots(int'(wrB), int'(rdB), 2, 3) >= 3 && waitCyc < 100) begin
                @(posedge clk); #1;
                waitCyc++;
            end
            checkOutput("B_wr_timeout", waitCyc >= 100, 0);
            memB[wrB[1:0]] = 8'hA0 + 8'(k);
            qB.push_back(8'hA0 + 8'(k));
            wrB = 3'(nextPtr(int'(wrB), 2, 3));
            @(posedge clk); #1;
        end
        waitCyc = 0;
        while (qB.size() != 0 && waitCyc < 100) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        checkOutput("B_drain_timeout", waitCyc >= 100, 0);
        @(negedge clk);
        expFinal = 0;
        for (int k = 0; k < 7; k++) expFinal = nextPtr(expFinal, 2, 3);
        checkOutput("B_rd_final", rdB, expFinal);
        checkOutput("B_wr_eq_rd", rdB, wrB);

        // C: eight words, downstream stalled; only the output FIFO's worth is read.
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            memC[k] = 8'hC0 + 8'(k);
            qC.push_back(8'hC0 + 8'(k));
        end
        wrC = 4'd8;
        repeat (15) @(negedge clk);
        checkOutput("C_sat_cnt", cntC, 4);
        checkOutput("C_sat_rd", rdC, 4);
        checkOutput("C_sat_issued", addrC, 4);
        checkOutput("C_sat_valid", validC, 1);
        checkOutput("C_sat_head", doutC, 8'hC0);

        // C: toggling backpressure drains all eight words in order.
        waitCyc = 0;
        while (qC.size() != 0 && waitCyc < 200) begin
            @(posedge clk); #1;
            readyC = ~readyC;
            waitCyc++;
        end
        readyC = 1'b0;
        checkOutput("C_drain_timeout", waitCyc >= 200, 0);
        repeat (3) @(negedge clk);
        checkOutput("C_rd_after_drain", rdC, 8);
        checkOutput("C_cnt_after_drain", cntC, 0);

        // C: flush with two words buffered and two reads in flight.
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) memC[k] = 8'hD0 + 8'(k);
        wrC = 4'd12;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("C_pre_flush_cnt", cntC, 2);
        flushC = 1'b1;
        @(posedge clk); #1;
        flushC = 1'b0;
        @(negedge clk);
        checkOutput("C_flush_valid", validC, 0);
        checkOutput("C_flush_cnt", cntC, 0);
        checkOutput("C_flush_rd", rdC, 12);
        readyC = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("C_post_flush_valid", validC, 0);
        checkOutput("C_post_flush_cnt", cntC, 0);
        checkOutput("C_post_flush_rd", rdC, 12);
        checkOutput("C_post_flush_addr", addrC, 4);

        // C: reset pulse in the middle of a stream, then resume from address 0.
        @(posedge clk); #1;
        monEnC = 1'b0;
        for (int k = 4; k < 7; k++) memC[k] = 8'hF0 + 8'(k);
        wrC = 4'd15;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstnC = 1'b0;
        #1;
        checkOutput("C_rst_valid", validC, 0);
        checkOutput("C_rst_cnt", cntC, 0);
        checkOutput("C_rst_rd", rdC, 0);
        checkOutput("C_rst_addr", addrC, 0);
        wrC = '0;
        @(negedge clk);
        rstnC = 1'b1;
        qC.delete();
        monEnC = 1'b1;
        @(posedge clk); #1;
        memC[0] = 8'hE0; memC[1] = 8'hE1;
        qC.push_back(8'hE0); qC.push_back(8'hE1);
        wrC = 4'd2;
        waitCyc = 0;
        while (qC.size() != 0 && waitCyc < 50) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        checkOutput("C_resume_timeout", waitCyc >= 50, 0);
        repeat (2) @(negedge clk);
        checkOutput("C_resume_rd", rdC, 2);
        checkOutput("C_resume_addr", addrC, 2);
        checkOutput("C_max_cnt", maxCntC, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
